// File: rtl/matrix_pkg.sv
// Shared types and width helpers for the matrix multiplier and its result-side blocks.
package matrix_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam int DROP_CNT_W = 16;

  // Element width of a k-term dot product of dw-bit operands.
  function automatic int c_data_width(input int dw, input int k);
    return 2 * dw + $clog2(k);
  endfunction

endpackage

// File: rtl/matrix_result_serializer.sv
// Captures a full multiplier result array and streams it out element by element
// in row-major order over a valid/ready handshake, dropping captures that collide with a frame.
module matrix_result_serializer
  import matrix_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int A_ROWS           = 10,
  parameter int B_COLUMNS        = 4,
  parameter int A_COLUMNS_B_ROWS = 6,
  parameter int C_DATA_WIDTH     = c_data_width(DATA_WIDTH, A_COLUMNS_B_ROWS),
  localparam int N               = A_ROWS * B_COLUMNS,
  localparam int ROW_W           = (A_ROWS > 1) ? $clog2(A_ROWS) : 1,
  localparam int COL_W           = (B_COLUMNS > 1) ? $clog2(B_COLUMNS) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    valid_i,
  input  logic [C_DATA_WIDTH-1:0] c_i [0:N-1],
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic [C_DATA_WIDTH-1:0] m_data_o,
  output logic [ROW_W-1:0]        m_row_o,
  output logic [COL_W-1:0]        m_col_o,
  output logic                    m_last_o,
  output logic                    busy_o,
  output logic                    drop_o,
  output logic [DROP_CNT_W-1:0]   drop_count_o
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  state_e                  state_reg, state_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic [ROW_W-1:0]        row_reg, row_next;
  logic [COL_W-1:0]        col_reg, col_next;
  logic                    drop_reg, drop_next;
  logic [DROP_CNT_W-1:0]   drop_cnt_reg;
  logic [C_DATA_WIDTH-1:0] buf_reg [0:N-1];

  logic sending, accept, last_beat, capture;

  assign sending   = (state_reg == SEND);
  assign accept    = sending && m_ready_i;
  assign last_beat = (idx_reg == IDX_W'(N - 1));
  // A capture landing on the final accept chains frames with no idle gap.
  assign capture   = valid_i && (!sending || (accept && last_beat));
  assign drop_next = valid_i && sending && !(accept && last_beat);

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    row_next   = row_reg;
    col_next   = col_reg;
    if (capture) begin
      state_next = SEND;
      idx_next   = '0;
      row_next   = '0;
      col_next   = '0;
    end else if (accept) begin
      if (last_beat) begin
        state_next = IDLE;
        idx_next   = '0;
        row_next   = '0;
        col_next   = '0;
      end else begin
        idx_next = idx_reg + IDX_W'(1);
        if (col_reg == COL_W'(B_COLUMNS - 1)) begin
          col_next = '0;
          row_next = row_reg + ROW_W'(1);
        end else begin
          col_next = col_reg + COL_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      row_reg      <= '0;
      col_reg      <= '0;
      drop_reg     <= 1'b0;
      drop_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      row_reg   <= row_next;
      col_reg   <= col_next;
      drop_reg  <= drop_next;
      if (drop_next && (drop_cnt_reg != '1)) begin
        drop_cnt_reg <= drop_cnt_reg + DROP_CNT_W'(1);
      end
    end
  end

  // Frame storage needs no reset; it is only observed while in SEND.
  always_ff @(posedge clk_i) begin
    if (capture) begin
      buf_reg <= c_i;
    end
  end

  assign m_valid_o    = sending;
  assign m_data_o     = sending ? buf_reg[idx_reg] : '0;
  assign m_row_o      = row_reg;
  assign m_col_o      = col_reg;
  assign m_last_o     = sending && last_beat;
  assign busy_o       = sending;
  assign drop_o       = drop_reg;
  assign drop_count_o = drop_cnt_reg;

endmodule
